matmul_seq_ctrl: RTL and testbench

- Sequencer that performs true signed matrix multiplication C = A×B by time-sharing one external combinational Booth multiplier (signed DW×DW → signed 2·DW).
- Holds A (M×K) and B (K×P) in internal register files loaded through a write port.
- Walks i/j/k in row-major order, accumulating products.
- Streams each C[i][j] out over a valid/ready handshake.

---
 rtl/matmul_seq_ctrl_if.sv | 47 ++++
 rtl/matmul_seq_ctrl.sv | 139 +++++++++++++
 tb/tb_matmul_seq_ctrl.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/matmul_seq_ctrl_if.sv
// Bus bundle for the matrix-multiply sequencer: element load port, run
// control, shared-multiplier operands and the result stream.
interface matmul_seq_ctrl_if #(
    parameter int M     = 3,
    parameter int K     = 3,
    parameter int P     = 3,
    parameter int DW    = 8,
    parameter int ACC_W = 18
);
    localparam int MXR = (M > K) ? M : K;
    localparam int MXC = (K > P) ? K : P;
    localparam int RW  = (MXR > 1) ? $clog2(MXR) : 1;
    localparam int CW  = (MXC > 1) ? $clog2(MXC) : 1;
    localparam int IW  = (M > 1) ? $clog2(M) : 1;
    localparam int JW  = (P > 1) ? $clog2(P) : 1;

    logic                wr_en;
    logic                wr_sel;
    logic [RW-1:0]       wr_row;
    logic [CW-1:0]       wr_col;
    logic [DW-1:0]       wr_data;
    logic                start;
    logic                busy;
    logic                done;
    logic [DW-1:0]       mul_a;
    logic [DW-1:0]       mul_b;
    logic [2*DW-1:0]     mul_p;
    logic                res_valid;
    logic                res_ready;
    logic [IW-1:0]       res_row;
    logic [JW-1:0]       res_col;
    logic [ACC_W-1:0]    res_data;

    modport master (
        input  wr_en, wr_sel, wr_row, wr_col, wr_data,
        input  start, mul_p, res_ready,
        output busy, done, mul_a, mul_b,
        output res_valid, res_row, res_col, res_data
    );

    modport slave (
        output wr_en, wr_sel, wr_row, wr_col, wr_data,
        output start, mul_p, res_ready,
        input  busy, done, mul_a, mul_b,
        input  res_valid, res_row, res_col, res_data
    );
endinterface

// File: rtl/matmul_seq_ctrl.sv
// Signed C = A x B sequencer sharing one external combinational multiplier;
// walks i/j/k row-major, one product per cycle, streams C over valid/ready.
module matmul_seq_ctrl #(
    parameter int M     = 3,
    parameter int K     = 3,
    parameter int P     = 3,
    parameter int DW    = 8,
    parameter int ACC_W = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    matmul_seq_ctrl_if.master bus
);
    localparam int IW = (M > 1) ? $clog2(M) : 1;
    localparam int JW = (P > 1) ? $clog2(P) : 1;
    localparam int KW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_EMIT,
        S_FIN
    } state_t;

    state_t                   r_state;
    logic signed [DW-1:0]     r_a [M][K];
    logic signed [DW-1:0]     r_b [K][P];
    logic [IW-1:0]            r_i;
    logic [JW-1:0]            r_j;
    logic [KW-1:0]            r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_valid;

    logic                     w_a_ok;
    logic                     w_b_ok;
    logic                     w_wr_a;
    logic                     w_wr_b;
    logic signed [ACC_W-1:0]  w_prod;
    logic                     w_last_k;
    logic                     w_last_j;
    logic                     w_last_ij;

    assign w_a_ok = (32'(bus.wr_row) < M) && (32'(bus.wr_col) < K);
    assign w_b_ok = (32'(bus.wr_row) < K) && (32'(bus.wr_col) < P);
    assign w_wr_a = bus.wr_en && !bus.wr_sel && w_a_ok;
    assign w_wr_b = bus.wr_en &&  bus.wr_sel && w_b_ok;

    assign w_prod = {{(ACC_W-2*DW){bus.mul_p[2*DW-1]}}, bus.mul_p};

    assign w_last_k  = (r_k == KW'(K-1));
    assign w_last_j  = (r_j == JW'(P-1));
    assign w_last_ij = w_last_j && (r_i == IW'(M-1));

    // Operands are only meaningful while accumulating; parked at zero otherwise.
    assign bus.mul_a = (r_state == S_MAC) ? r_a[r_i][r_k] : '0;
    assign bus.mul_b = (r_state == S_MAC) ? r_b[r_k][r_j] : '0;

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.res_valid = r_valid;
    assign bus.res_row   = r_i;
    assign bus.res_col   = r_j;
    assign bus.res_data  = r_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_i     <= '0;
            r_j     <= '0;
            r_k     <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            for (int m = 0; m < M; m++)
                for (int n = 0; n < K; n++)
                    r_a[m][n] <= '0;
            for (int m = 0; m < K; m++)
                for (int n = 0; n < P; n++)
                    r_b[m][n] <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    unique case (1'b1)
                        w_wr_a:
                            r_a[bus.wr_row[IW-1:0]][bus.wr_col[KW-1:0]]
                                <= bus.wr_data;
                        w_wr_b:
                            r_b[bus.wr_row[KW-1:0]][bus.wr_col[JW-1:0]]
                                <= bus.wr_data;
                        default: ;
                    endcase
                    if (bus.start) begin
                        r_state <= S_MAC;
                        r_busy  <= 1'b1;
                        r_i     <= '0;
                        r_j     <= '0;
                        r_k     <= '0;
                    end
                end
                S_MAC: begin
                    r_acc <= (r_k == '0) ? w_prod : r_acc + w_prod;
                    if (w_last_k) begin
                        r_k     <= '0;
                        r_state <= S_EMIT;
                        r_valid <= 1'b1;
                    end else begin
                        r_k <= r_k + 1'b1;
                    end
                end
                S_EMIT: begin
                    if (bus.res_ready) begin
                        r_valid <= 1'b0;
                        if (w_last_ij) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_MAC;
                            if (w_last_j) begin
                                r_j <= '0;
                                r_i <= r_i + 1'b1;
                            end else begin
                                r_j <= r_j + 1'b1;
                            end
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Bench for matmul_seq_ctrl: directed table of matrices plus random matrices
// checked against a plain nested-loop product.
module tb_matmul_seq_ctrl;
    localparam int M = 3, K = 3, P = 3, DW = 8, ACC_W = 18;

    typedef logic [0:8][7:0]  m8_t;
    typedef logic [0:8][17:0] m18_t;
    typedef struct packed {
        m8_t  a;
        m8_t  b;
        m18_t c;
        int   sidx;
        int   sn;
        int   lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if #(.M(M), .K(K), .P(P), .DW(DW), .ACC_W(ACC_W)) bus();

    assign bus.mul_p = 16'($signed(bus.mul_a)) * 16'($signed(bus.mul_b));

    matmul_seq_ctrl #(.M(M), .K(K), .P(P), .DW(DW), .ACC_W(ACC_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   nerr = 0;
    int   nchk = 0;
    int   ma [9];
    int   mb [9];
    int   exp_c [9];
    vec_t vt [3];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic wr(input bit sel, input int r, input int c, input int d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_sel  = sel;
        bus.wr_row  = 2'(r);
        bus.wr_col  = 2'(c);
        bus.wr_data = 8'(d);
        @(posedge clk);
        #1 bus.wr_en = 1'b0;
    endtask

    task automatic load();
        for (int e = 0; e < 9; e++) begin
            wr(1'b0, e / 3, e % 3, ma[e]);
            wr(1'b1, e / 3, e % 3, mb[e]);
        end
    endtask

    function automatic void model();
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s = 0;
                for (int k = 0; k < 3; k++)
                    s += ma[i*3+k] * mb[k*3+j];
                exp_c[i*3+j] = s;
            end
    endfunction

    // mode 0: ready high, 1: stall result sidx for sn cycles, 2: random ready
    task automatic run(input int mode, input int sidx, input int sn,
                       input bit inj, input bit ws, input int wsd,
                       input int lat);
        int cyc, nres, left, dcyc;
        bit fin;
        cyc = 0; nres = 0; left = sn; fin = 1'b0; dcyc = -1;
        @(posedge clk);
        #1 bus.start = 1'b1;
        bus.res_ready = 1'b1;
        if (ws) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b1;
            bus.wr_row = 2'd2; bus.wr_col = 2'd2; bus.wr_data = 8'(wsd);
        end
        @(posedge clk);
        cyc = 1;
        #1 bus.start = 1'b0;
        bus.wr_en = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            chk("busy_run", int'(bus.busy), 1);
            if (inj) begin
                if (cyc == 10) begin
                    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
                    bus.wr_row = 2'd0; bus.wr_col = 2'd0; bus.wr_data = 8'd99;
                end else begin
                    bus.start = 1'b0; bus.wr_en = 1'b0;
                end
            end
            if (bus.done) begin
                fin = 1'b1;
                dcyc = cyc;
            end else if (bus.res_valid) begin
                if (nres >= 9) begin
                    chk("extra_result", nres, 8);
                end else begin
                    chk("res_data", int'($signed(bus.res_data)), exp_c[nres]);
                    chk("res_idx", int'(bus.res_row) * 3 + int'(bus.res_col), nres);
                end
                case (mode)
                    1: if (nres == sidx && left > 0) begin
                           bus.res_ready = 1'b0;
                           left--;
                       end else bus.res_ready = 1'b1;
                    2: bus.res_ready = ($urandom_range(0, 2) != 0);
                    default: bus.res_ready = 1'b1;
                endcase
                if (bus.res_ready) nres++;
            end else begin
                bus.res_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (!fin) begin
                @(posedge clk);
                cyc++;
            end
        end
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        if (!fin) chk("done_timeout", 0, 1);
        chk("n_results", nres, 9);
        if (lat >= 0) chk("done_latency", dcyc, lat);
    endtask

    initial begin
        vt[0] = '{a: {8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01},
                  b: {8'h01, 8'h02, 8'h03, 8'hFC, 8'hFB, 8'hFA, 8'h07, 8'h08, 8'h7F},
                  c: {18'h00001, 18'h00002, 18'h00003,
                      18'h3FFFC, 18'h3FFFB, 18'h3FFFA,
                      18'h00007, 18'h00008, 18'h0007F},
                  sidx: -1, sn: 0, lat: 37};
        vt[1] = '{a: {9{8'h80}}, b: {9{8'h80}}, c: {9{18'h0C000}},
                  sidx: -1, sn: 0, lat: 37};
        vt[2] = '{a: {9{8'h01}},
                  b: {8'h02, 8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'hFC},
                  c: {3{18'h00002, 18'h00003, 18'h3FFFC}},
                  sidx: 1, sn: 5, lat: 42};

        bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
        bus.wr_data = '0; bus.start = 1'b0; bus.res_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_valid", int'(bus.res_valid), 0);
        chk("rst_data", int'(bus.res_data), 0);
        chk("rst_row", int'(bus.res_row), 0);
        chk("rst_col", int'(bus.res_col), 0);
        chk("rst_mul_a", int'(bus.mul_a), 0);
        chk("rst_mul_b", int'(bus.mul_b), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 3; v++) begin
            for (int e = 0; e < 9; e++) begin
                ma[e] = int'($signed(vt[v].a[e]));
                mb[e] = int'($signed(vt[v].b[e]));
                exp_c[e] = int'($signed(vt[v].c[e]));
            end
            load();
            run((vt[v].sidx >= 0) ? 1 : 0, vt[v].sidx, vt[v].sn,
                1'b0, 1'b0, 0, vt[v].lat);
            @(negedge clk);
            chk("done_one_cycle", int'(bus.done), 0);
            chk("busy_after_fin", int'(bus.busy), 0);
        end

        // start/wr_en pulsed mid-run must not disturb the vt[2] product
        run(0, -1, 0, 1'b1, 1'b0, 0, 37);
        run(0, -1, 0, 1'b0, 1'b0, 0, 37);

        for (int it = 0; it < 3; it++) begin
            for (int e = 0; e < 9; e++) begin
                ma[e] = int'($urandom_range(0, 255)) - 128;
                mb[e] = int'($urandom_range(0, 255)) - 128;
            end
            load();
            wr(1'b0, 3, 0, 55);
            wr(1'b0, 0, 3, 55);
            wr(1'b1, 3, 1, 55);
            wr(1'b1, 1, 3, 55);
            model();
            run(2, -1, 0, 1'b0, 1'b0, 0, -1);
            run(0, -1, 0, 1'b0, 1'b0, 0, 37);
        end

        // write landing on the same edge as start
        mb[8] = -77;
        model();
        run(0, -1, 0, 1'b0, 1'b1, -77, 37);

        // reset in the middle of C[1][1] accumulation
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (17) @(posedge clk);
        #2;
        chk("mid_busy", int'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_valid", int'(bus.res_valid), 0);
        chk("abort_done", int'(bus.done), 0);
        chk("abort_data", int'(bus.res_data), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 0; e < 9; e++) begin
            ma[e] = 0;
            mb[e] = 0;
        end
        model();
        run(0, -1, 0, 1'b0, 1'b0, 0, 37);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
